// File: rtl/paint_pkg.sv
// Shared constants for the paint cursor controller: direction bit positions,
// FSM state encoding and the largest brush edge in pixels.
package paint_pkg;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_PAINT = 1'b1;

    localparam int BRUSH_MAX = 4;

endpackage

// File: rtl/step_tick.sv
// Free-running divider producing a registered one-cycle tick every STEP_DIV
// clocks; the tick is high exactly while the count sits at STEP_DIV-1.
module step_tick #(
    parameter int STEP_DIV = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNTW = $clog2(STEP_DIV);
    localparam logic [CNTW-1:0] LAST = CNTW'(STEP_DIV - 1);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            tick_q;
    logic            tick_d;

    // Next count with wrap at the last step value.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d = {CNTW{1'b0}};
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d = (cnt_d == LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= {CNTW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/paint_cursor_ctrl.sv
// Cursor mover and brush painter: steps the cursor on divider ticks and, with the
// pen down, bursts the square brush footprint out as single-pixel write requests.
module paint_cursor_ctrl
    import paint_pkg::*;
#(
    parameter int XW       = 8,
    parameter int YW       = 8,
    parameter int CW       = 12,
    parameter int STEP_DIV = 20_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      dir,
    input  logic            draw,
    input  logic [CW-1:0]   rgb,
    input  logic [1:0]      brush,
    output logic            we,
    output logic [XW+YW-1:0] waddr,
    output logic [CW-1:0]   wdata,
    input  logic            wready,
    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic            busy
);

    localparam int BIW = $clog2(BRUSH_MAX);
    localparam logic [XW-1:0] X_HOME = {1'b1, {(XW-1){1'b0}}};
    localparam logic [YW-1:0] Y_HOME = {1'b1, {(YW-1){1'b0}}};
    localparam logic [XW-1:0] X_MAX  = {XW{1'b1}};
    localparam logic [YW-1:0] Y_MAX  = {YW{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             pending_q, pending_d;
    logic             draw_q;
    logic [XW-1:0]    x0_q, x0_d;
    logic [YW-1:0]    y0_q, y0_d;
    logic [CW-1:0]    rgb_q, rgb_d;
    logic [BIW-1:0]   brush_q, brush_d;
    logic [BIW-1:0]   i_q, i_d;
    logic [BIW-1:0]   j_q, j_d;
    logic             we_q, we_d;
    logic [XW+YW-1:0] waddr_q, waddr_d;
    logic [CW-1:0]    wdata_q, wdata_d;

    logic             tick_s;
    logic             idle_s;
    logic             enter_s;
    logic             moved_s;
    logic             rise_s;
    logic [XW:0]      px_next_s;
    logic [YW:0]      py_next_s;
    logic [YW-1:0]    py_cur_s;
    logic             col_ok_s;
    logic             row_ok_s;

    step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign idle_s  = (state_q == ST_IDLE);
    assign enter_s = idle_s && pending_q && draw;
    assign rise_s  = draw && !draw_q;

    // Saturating cursor step; opposite directions cancel.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        moved_s = 1'b0;
        if (idle_s && tick_s) begin
            if (dir[DIR_RIGHT] && !dir[DIR_LEFT] && (x_q != X_MAX)) begin
                x_d = x_q + 1'b1;
            end else if (dir[DIR_LEFT] && !dir[DIR_RIGHT] && (x_q != {XW{1'b0}})) begin
                x_d = x_q - 1'b1;
            end else begin
                x_d = x_q;
            end
            if (dir[DIR_UP] && !dir[DIR_DOWN] && (y_q != Y_MAX)) begin
                y_d = y_q + 1'b1;
            end else if (dir[DIR_DOWN] && !dir[DIR_UP] && (y_q != {YW{1'b0}})) begin
                y_d = y_q - 1'b1;
            end else begin
                y_d = y_q;
            end
            moved_s = (x_d != x_q) || (y_d != y_q);
        end else begin
            moved_s = 1'b0;
        end
    end

    // Off-canvas pixels form a suffix of each row and of the column of rows,
    // so one look-ahead per axis finds the next visible pixel without a spare cycle.
    always_comb begin
        px_next_s = {1'b0, x0_q} + (XW+1)'(i_q) + (XW+1)'(1'b1);
        py_next_s = {1'b0, y0_q} + (YW+1)'(j_q) + (YW+1)'(1'b1);
        py_cur_s  = y0_q + YW'(j_q);
        col_ok_s  = (i_q < brush_q) && !px_next_s[XW];
        row_ok_s  = (j_q < brush_q) && !py_next_s[YW];
    end

    // Pending request: a real move or pen-down edge, cleared by burst start or pen-up.
    always_comb begin
        pending_d = pending_q;
        if (!draw) begin
            pending_d = 1'b0;
        end else if (moved_s || rise_s) begin
            pending_d = 1'b1;
        end else if (enter_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Burst sequencer: latch the brush on entry, then walk it row-major.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        rgb_d   = rgb_q;
        brush_d = brush_q;
        i_d     = i_q;
        j_d     = j_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (enter_s) begin
                    state_d = ST_PAINT;
                    x0_d    = x_q;
                    y0_d    = y_q;
                    rgb_d   = rgb;
                    brush_d = brush;
                    i_d     = {BIW{1'b0}};
                    j_d     = {BIW{1'b0}};
                    we_d    = 1'b1;
                    waddr_d = {y_q, x_q};
                    wdata_d = rgb;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAINT: begin
                if (we_q && wready) begin
                    if (col_ok_s) begin
                        i_d     = i_q + 1'b1;
                        waddr_d = {py_cur_s, px_next_s[XW-1:0]};
                    end else if (row_ok_s) begin
                        i_d     = {BIW{1'b0}};
                        j_d     = j_q + 1'b1;
                        waddr_d = {py_next_s[YW-1:0], x0_q};
                    end else begin
                        state_d = ST_IDLE;
                        we_d    = 1'b0;
                        waddr_d = {(XW+YW){1'b0}};
                        wdata_d = {CW{1'b0}};
                    end
                end else begin
                    state_d = ST_PAINT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
                waddr_d = {(XW+YW){1'b0}};
                wdata_d = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= X_HOME;
            y_q       <= Y_HOME;
            pending_q <= 1'b0;
            draw_q    <= 1'b0;
            x0_q      <= {XW{1'b0}};
            y0_q      <= {YW{1'b0}};
            rgb_q     <= {CW{1'b0}};
            brush_q   <= {BIW{1'b0}};
            i_q       <= {BIW{1'b0}};
            j_q       <= {BIW{1'b0}};
            we_q      <= 1'b0;
            waddr_q   <= {(XW+YW){1'b0}};
            wdata_q   <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pending_q <= pending_d;
            draw_q    <= draw;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            rgb_q     <= rgb_d;
            brush_q   <= brush_d;
            i_q       <= i_d;
            j_q       <= j_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign x     = x_q;
    assign y     = y_q;
    assign busy  = (state_q == ST_PAINT);

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// Directed scenarios plus a random walk, each cycle compared against a pixel-list
// model of cursor motion and brush bursts.
module tb_paint_cursor_ctrl;

    localparam int SD = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  dir;
    logic        draw;
    logic [11:0] rgb;
    logic [1:0]  brush;
    logic        wready;
    logic        we;
    logic [15:0] waddr;
    logic [11:0] wdata;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int m_cnt, m_x, m_y, m_addr, m_data;
    bit m_pend, m_busy, m_we, m_draw_prev, m_last_tick;
    int m_q[$];

    int d_log[$];
    int d_dat[$];

    paint_cursor_ctrl #(.XW(8), .YW(8), .CW(12), .STEP_DIV(SD)) dut (
        .clk(clk), .rst(rst), .dir(dir), .draw(draw), .rgb(rgb), .brush(brush),
        .we(we), .waddr(waddr), .wdata(wdata), .wready(wready),
        .x(x), .y(y), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && we === 1'b1 && wready === 1'b1) begin
            d_log.push_back(int'(waddr));
            d_dat.push_back(int'(wdata));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp255(int v);
        if (v < 0) return 0;
        else if (v > 255) return 255;
        else return v;
    endfunction

    function automatic int log_at(int k);
        if (k < d_log.size()) return d_log[k];
        else return -1;
    endfunction

    function automatic int dat_at(int k);
        if (k < d_dat.size()) return d_dat[k];
        else return -1;
    endfunction

    task automatic model_step();
        bit tick, rise, enter, moved;
        int nx, ny;
        if (rst) begin
            m_cnt = 0; m_x = 128; m_y = 128; m_pend = 0; m_busy = 0;
            m_we = 0; m_addr = 0; m_data = 0; m_draw_prev = 0; m_last_tick = 0;
            m_q.delete();
            return;
        end
        tick = (m_cnt == SD - 1);
        m_last_tick = tick;
        m_cnt = tick ? 0 : m_cnt + 1;
        rise = draw && !m_draw_prev;
        if (!m_busy) begin
            enter = m_pend && draw;
            if (enter) begin
                m_q.delete();
                for (int j = 0; j <= int'(brush); j++)
                    for (int i = 0; i <= int'(brush); i++)
                        if (m_x + i < 256 && m_y + j < 256)
                            m_q.push_back((m_y + j) * 256 + m_x + i);
                m_busy = 1; m_we = 1; m_addr = m_q[0]; m_data = int'(rgb);
            end
            moved = 0;
            if (tick) begin
                nx = clamp255(m_x + int'(dir[3]) - int'(dir[2]));
                ny = clamp255(m_y + int'(dir[0]) - int'(dir[1]));
                moved = (nx != m_x) || (ny != m_y);
                m_x = nx; m_y = ny;
            end
            m_pend = draw && (moved || rise || (m_pend && !enter));
        end else begin
            if (m_we && wready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 0; m_we = 0; m_addr = 0; m_data = 0;
                end else begin
                    m_addr = m_q[0];
                end
            end
            m_pend = draw && (rise || m_pend);
        end
        m_draw_prev = draw;
    endtask

    task automatic check_outputs();
        chk("x", x, m_x);
        chk("y", y, m_y);
        chk("we", we, m_we);
        chk("busy", busy, m_busy);
        chk("waddr", waddr, m_addr);
        chk("wdata", wdata, m_data);
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic run_ticks(input int n);
        int t = 0;
        int budget = n * SD + 8;
        while (t < n && budget > 0) begin
            cyc();
            if (m_last_tick) t++;
            budget--;
        end
        chk("tick_budget", t, n);
    endtask

    initial begin
        int waited;
        rst = 1'b1; dir = 4'b0000; draw = 1'b0; rgb = 12'h000; brush = 2'd0; wready = 1'b1;
        cyc(); cyc();
        chk("rst_x", x, 32'd128);
        chk("rst_y", y, 32'd128);
        chk("rst_we", we, 32'd0);
        chk("rst_busy", busy, 32'd0);
        rst = 1'b0;

        // right for 3 ticks, then to the right edge, then up+right at the edge
        dir = 4'b1000;
        run_ticks(3);
        chk("right3_x", x, 32'd131);
        chk("right3_y", y, 32'd128);
        run_ticks(124);
        chk("edge_x", x, 32'd255);
        dir = 4'b1001;
        run_ticks(2);
        chk("diag_x", x, 32'd255);
        chk("diag_y", y, 32'd130);
        chk("diag_nowrite", d_log.size(), 32'd0);

        // travel to (10,20)
        dir = 4'b0110;
        run_ticks(110);
        dir = 4'b0100;
        run_ticks(135);
        chk("at10_x", x, 32'd10);
        chk("at20_y", y, 32'd20);
        dir = 4'b0000;
        run(2);

        // 2x2 brush burst
        brush = 2'd1; rgb = 12'hF00; d_log.delete(); d_dat.delete();
        draw = 1'b1;
        run(12);
        chk("b2_count", d_log.size(), 32'd4);
        chk("b2_a0", log_at(0), 32'd20 * 256 + 10);
        chk("b2_a1", log_at(1), 32'd20 * 256 + 11);
        chk("b2_a2", log_at(2), 32'd21 * 256 + 10);
        chk("b2_a3", log_at(3), 32'd21 * 256 + 11);
        for (int k = 0; k < 4; k++) chk("b2_data", dat_at(k), 32'hF00);
        chk("b2_idle", busy, 32'd0);

        // same burst with a 5-cycle stall on pixel 2
        draw = 1'b0; cyc();
        d_log.delete(); d_dat.delete();
        draw = 1'b1;
        waited = 0;
        while (!(m_busy && m_q.size() == 3) && waited < 10) begin
            cyc();
            waited++;
        end
        chk("stall_reach_px2", waited < 10, 32'd1);
        wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_we", we, 32'd1);
            chk("stall_addr", waddr, 32'd20 * 256 + 11);
            chk("stall_data", wdata, 32'hF00);
        end
        wready = 1'b1;
        run(10);
        chk("stall_count", d_log.size(), 32'd4);
        chk("stall_a0", log_at(0), 32'd20 * 256 + 10);
        chk("stall_a1", log_at(1), 32'd20 * 256 + 11);
        chk("stall_a2", log_at(2), 32'd21 * 256 + 10);
        chk("stall_a3", log_at(3), 32'd21 * 256 + 11);

        // corner clipping at (254,255) with a 4x4 brush
        draw = 1'b0;
        dir = 4'b1001;
        run_ticks(244);
        chk("corner_x", x, 32'd254);
        chk("corner_y", y, 32'd255);
        dir = 4'b0000; brush = 2'd3; rgb = 12'h0A5;
        d_log.delete(); d_dat.delete();
        draw = 1'b1;
        run(12);
        chk("clip_count", d_log.size(), 32'd2);
        chk("clip_a0", log_at(0), 32'd255 * 256 + 254);
        chk("clip_a1", log_at(1), 32'd255 * 256 + 255);
        chk("clip_d0", dat_at(0), 32'h0A5);
        chk("clip_idle", busy, 32'd0);

        // reset in the middle of a 16-pixel burst
        draw = 1'b0;
        dir = 4'b0110;
        run_ticks(4);
        dir = 4'b0000;
        d_log.delete(); d_dat.delete();
        draw = 1'b1;
        waited = 0;
        while (d_log.size() < 2 && waited < 20) begin
            cyc();
            waited++;
        end
        chk("abort_two_writes", d_log.size(), 32'd2);
        chk("abort_a1", log_at(1), 32'd251 * 256 + 251);
        rst = 1'b1; draw = 1'b0;
        cyc();
        chk("abort_we", we, 32'd0);
        chk("abort_x", x, 32'd128);
        chk("abort_y", y, 32'd128);
        chk("abort_busy", busy, 32'd0);
        rst = 1'b0;
        run(20);
        chk("abort_no_more", d_log.size(), 32'd2);

        // random walk
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) dir = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) draw = ~draw;
            if ($urandom_range(0, 15) == 0) brush = 2'($urandom_range(0, 3));
            rgb    = 12'($urandom_range(0, 4095));
            wready = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 599) == 0);
            cyc();
        end
        rst = 1'b0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
